// File: rtl/cursor_overlay.sv
// cursor_overlay: composites a computed 16x16 arrow cursor onto the pixel stream,
// latching the clamped mouse position at frame start and auto-hiding when idle.
module cursor_overlay #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int CUR_SIZE    = 16,
   parameter int HIDE_FRAMES = 300
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] pos_x_i,
   input  logic [11:0] pos_y_i,
   input  logic        frame_start_i,
   input  logic [9:0]  draw_x_i,
   input  logic [9:0]  draw_y_i,
   input  logic        pixel_en_i,
   input  logic [23:0] pixel_in_i,
   output logic [23:0] pixel_out_o,
   output logic        pixel_en_out_o,
   output logic        cursor_hit_o,
   output logic        cursor_visible_o
);
   localparam int IW = $clog2(HIDE_FRAMES + 2);
   localparam logic [11:0]   XMAX = 12'(H_ACTIVE - 1);
   localparam logic [11:0]   YMAX = 12'(V_ACTIVE - 1);
   localparam logic [IW-1:0] HF   = IW'(HIDE_FRAMES);
   localparam logic [12:0]   CS   = 13'(CUR_SIZE);
   logic [11:0]   cx, cy, cur_x_q, cur_y_q;
   logic [IW-1:0] idle_q, idle_inc;
   logic [12:0]   dx, dy;
   logic          vis_q, moved, in_box, opaque, black;
   logic          hit1_q, blk1_q, en1_q;
   logic [23:0]   pix1_q;
   assign cx       = pos_x_i > XMAX ? XMAX : pos_x_i;
   assign cy       = pos_y_i > YMAX ? YMAX : pos_y_i;
   assign moved    = cx != cur_x_q || cy != cur_y_q;
   assign idle_inc = idle_q + 1'b1;
   // Bit 12 is the sign of the 13-bit difference; negative means left of/above the box.
   assign dx     = {3'b0, draw_x_i} - {1'b0, cur_x_q};
   assign dy     = {3'b0, draw_y_i} - {1'b0, cur_y_q};
   assign in_box = !dx[12] && !dy[12] && dx < CS && dy < CS;
   assign opaque = in_box && dx <= dy;
   assign black  = dx == 13'd0 || dx == dy || dy == CS - 13'd1;
   assign cursor_visible_o = vis_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_x_q        <= '0;
         cur_y_q        <= '0;
         idle_q         <= '0;
         vis_q          <= 1'b1;
         hit1_q         <= 1'b0;
         blk1_q         <= 1'b0;
         en1_q          <= 1'b0;
         pix1_q         <= '0;
         pixel_out_o    <= '0;
         pixel_en_out_o <= 1'b0;
         cursor_hit_o   <= 1'b0;
      end else begin
         if (frame_start_i) begin
            cur_x_q <= cx;
            cur_y_q <= cy;
            if (moved) begin
               idle_q <= '0;
               vis_q  <= 1'b1;
            end else if (idle_q < HF) begin
               idle_q <= idle_inc;
               if (idle_inc == HF) vis_q <= 1'b0;
            end
         end
         hit1_q         <= opaque && vis_q && pixel_en_i;
         blk1_q         <= black;
         en1_q          <= pixel_en_i;
         pix1_q         <= pixel_in_i;
         pixel_en_out_o <= en1_q;
         cursor_hit_o   <= hit1_q;
         pixel_out_o    <= !en1_q ? 24'h0 : hit1_q ? (blk1_q ? 24'h0 : 24'hFFFFFF) : pix1_q;
      end
   end
endmodule

// File: tb/tb_cursor_overlay.sv
// tb_cursor_overlay: directed vectors for cursor_overlay with hand-computed expectations.
module tb_cursor_overlay;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] pos_x = '0, pos_y = '0;
   logic        frame_start = 1'b0;
   logic [9:0]  draw_x = '0, draw_y = '0;
   logic        pixel_en = 1'b0;
   logic [23:0] pixel_in = '0;
   logic [23:0] pixel_out;
   logic        pixel_en_out, cursor_hit, cursor_visible;
   int          checks = 0, errors = 0;

   cursor_overlay #(.HIDE_FRAMES(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .pos_x_i(pos_x), .pos_y_i(pos_y), .frame_start_i(frame_start),
      .draw_x_i(draw_x), .draw_y_i(draw_y), .pixel_en_i(pixel_en), .pixel_in_i(pixel_in),
      .pixel_out_o(pixel_out), .pixel_en_out_o(pixel_en_out),
      .cursor_hit_o(cursor_hit), .cursor_visible_o(cursor_visible)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic frame(input logic [11:0] x, input logic [11:0] y);
      pos_x = x;
      pos_y = y;
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   // One pixel in, one idle cycle, then sample: only a 2-cycle latency lands the result here.
   task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic en,
                      input logic [23:0] d, input logic [23:0] exp_pix, input logic exp_hit);
      draw_x = x;
      draw_y = y;
      pixel_en = en;
      pixel_in = d;
      @(posedge clk); #1;
      pixel_en = 1'b0;
      pixel_in = 24'h0;
      @(posedge clk); #1;
      check({tag, ".pix"}, pixel_out, exp_pix);
      check({tag, ".hit"}, {23'b0, cursor_hit}, {23'b0, exp_hit});
      check({tag, ".en"}, {23'b0, pixel_en_out}, {23'b0, en});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      draw_x = 10'd300; draw_y = 10'd200; pixel_en = 1'b1; pixel_in = 24'h123456;
      repeat (2) @(posedge clk);
      #1 check("pre_rst.pix", pixel_out, 24'h123456);
      #2 reset_n = 1'b0;
      #1;
      check("rst.pix", pixel_out, 24'h0);
      check("rst.en", {23'b0, pixel_en_out}, 24'h0);
      check("rst.hit", {23'b0, cursor_hit}, 24'h0);
      check("rst.vis", {23'b0, cursor_visible}, 24'h1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      pix("post_rst", 10'd300, 10'd200, 1'b1, 24'h123456, 24'h123456, 1'b0);
      pix("origin", 10'd0, 10'd0, 1'b1, 24'h777777, 24'h000000, 1'b1);

      frame(12'd100, 12'd50);
      pix("c100_52", 10'd100, 10'd52, 1'b1, 24'hAAAAAA, 24'h000000, 1'b1);
      pix("c101_52", 10'd101, 10'd52, 1'b1, 24'hAAAAAA, 24'hFFFFFF, 1'b1);
      pix("c102_52", 10'd102, 10'd52, 1'b1, 24'hAAAAAA, 24'h000000, 1'b1);
      pix("c103_52", 10'd103, 10'd52, 1'b1, 24'hAAAAAA, 24'hAAAAAA, 1'b0);
      pix("bottom_row", 10'd105, 10'd65, 1'b1, 24'hAAAAAA, 24'h000000, 1'b1);
      pix("below_box", 10'd100, 10'd66, 1'b1, 24'h010203, 24'h010203, 1'b0);

      frame(12'hFFF, 12'hFFF);
      pix("clamp_639", 10'd639, 10'd479, 1'b1, 24'h5A5A5A, 24'h000000, 1'b1);
      pix("clamp_638", 10'd638, 10'd479, 1'b1, 24'h5A5A5A, 24'h5A5A5A, 1'b0);

      frame(12'd100, 12'd50);
      pos_x = 12'd200;
      pos_y = 12'd60;
      pix("latch_old", 10'd100, 10'd50, 1'b1, 24'h0F0F0F, 24'h000000, 1'b1);
      pix("latch_new", 10'd200, 10'd60, 1'b1, 24'h0F0F0F, 24'h0F0F0F, 1'b0);
      frame(12'd200, 12'd60);
      pix("swap_old", 10'd100, 10'd50, 1'b1, 24'h0F0F0F, 24'h0F0F0F, 1'b0);
      pix("swap_new", 10'd200, 10'd60, 1'b1, 24'h0F0F0F, 24'h000000, 1'b1);

      frame(12'd100, 12'd50);
      frame(12'd100, 12'd50);
      frame(12'd100, 12'd50);
      check("idle2.vis", {23'b0, cursor_visible}, 24'h1);
      frame(12'd100, 12'd50);
      check("idle3.vis", {23'b0, cursor_visible}, 24'h0);
      pix("hidden", 10'd100, 10'd50, 1'b1, 24'h332211, 24'h332211, 1'b0);
      frame(12'd100, 12'd50);
      check("idle4.vis", {23'b0, cursor_visible}, 24'h0);
      frame(12'd101, 12'd50);
      check("moved.vis", {23'b0, cursor_visible}, 24'h1);
      pix("reshown", 10'd101, 10'd50, 1'b1, 24'h332211, 24'h000000, 1'b1);

      pix("blank", 10'd101, 10'd50, 1'b0, 24'hABCDEF, 24'h000000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cursor_overlay.md
# cursor_overlay

Pixel-pipeline stage that consumes the 12-bit mouse position words driven by the SoC's position PIO output ports (X and Y) and composites a 16x16 arrow cursor onto the VGA pixel stream. Position is clamped to the visible area and sampled only at frame start, so the cursor never tears mid-frame. After a configurable number of frames without movement the cursor auto-hides, and it reappears on the next movement. The block sits between the background/sprite renderer and the VGA DAC output registers.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CUR_SIZE, 16, cursor width and height in pixels
- HIDE_FRAMES, 300, unchanged frames before the cursor hides; 0 disables hiding
- clk  in  1  pixel clock
- reset_n  in  1  reset, asynchronous, active-low
- pos_x  in  12  mouse X from the PIO out_port, unsigned, level (no valid strobe)
- pos_y  in  12  mouse Y from the PIO out_port, unsigned, level
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- pixel_en  in  1  active-video qualifier for draw_x/draw_y/pixel_in
- pixel_in  in  24  background RGB 8:8:8
- pixel_out  out  24  composited RGB, delayed 2 cycles
- pixel_en_out  out  1  pixel_en delayed 2 cycles
- cursor_hit  out  1  1 when pixel_out is an opaque cursor pixel, delayed 2 cycles
- cursor_visible  out  1  current visibility state

## Operation
- Clamp (combinational): cx = min(pos_x, H_ACTIVE-1), cy = min(pos_y, V_ACTIVE-1).
- Shadow registers cur_x and cur_y load cx and cy only in cycles with frame_start=1. Changes to pos_x/pos_y at any other time have no effect until the next frame_start.
- Idle logic, evaluated on each frame_start:
  - If cx != cur_x or cy != cur_y: clear idle_cnt to 0 and set visible=1.
  - Otherwise, if idle_cnt < HIDE_FRAMES: increment idle_cnt. If the incremented value equals HIDE_FRAMES, clear visible.
  - idle_cnt saturates at HIDE_FRAMES.
  - HIDE_FRAMES=0: visible stays 1 permanently.
- Hit test: dx = {2'b0,draw_x} - cur_x and dy = {2'b0,draw_y} - cur_y, computed at 13-bit signed. The pixel is inside the cursor box when 0<=dx<CUR_SIZE and 0<=dy<CUR_SIZE. Let r=dy and c=dx.
- Bitmap (computed, no ROM):
  - c>r: transparent.
  - c==0, c==r, or r==CUR_SIZE-1: black, 000000.
  - Otherwise: white, FFFFFF.
- Output selection:
  - Opaque pixel, in box, visible=1, pixel_en=1: pixel_out is the cursor colour and cursor_hit=1.
  - pixel_en=1 in any other case: pixel_out = pixel_in and cursor_hit=0.
  - pixel_en=0: pixel_out=0 and cursor_hit=0.
- Clipping at the right and bottom screen edges is implicit, because draw_x/draw_y never exceed the active area.

## Timing
- Stage 1 registers: in-box flag, colour class, delayed pixel_in, delayed pixel_en. Stage 2 registers: pixel_out, cursor_hit, pixel_en_out.
- Total latency is exactly 2 clk from input to output, with a throughput of 1 pixel/clk and no stalls.
- A shadow-register update on frame_start affects hit testing from the next cycle onward.
- frame_start coincident with a pos_x/pos_y change: the value present in that cycle is sampled.
- Reset values:
  - pixel_out=0, pixel_en_out=0, cursor_hit=0.
  - cur_x=0, cur_y=0, idle_cnt=0.
  - cursor_visible=1.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). After release, valid output resumes 2 cycles after the first pixel_en=1.

## Test plan
- Reset: assert reset_n=0 during active video with pixel_in=123456 -> all outputs 0 and cursor_visible=1. Release reset, then apply pixel_en=1 -> pixel_out=123456 two cycles later.
- Colours: set pos=(100,50), pulse frame_start, then sweep row 52.
  - (100,52) -> 000000 with cursor_hit=1.
  - (101,52) -> FFFFFF.
  - (102,52) -> 000000.
  - (103,52) -> pixel_in passes through with cursor_hit=0.
  - Each output appears exactly 2 cycles after its input.
- Clamp: set pos_x=FFF and pos_y=FFF, then pulse frame_start -> cur=(639,479). Pixel (639,479) -> 000000. Pixel (638,479) -> pixel_in.
- Frame latch: with the cursor at (100,50), change pos to (200,60) mid-frame -> (100,50) is still black and (200,60) passes through. After the next frame_start, the two results swap.
- Auto-hide with HIDE_FRAMES=3 and position held:
  - After 3 frame_starts: cursor_visible=0 and (100,50) passes pixel_in.
  - Move to (101,50) and pulse frame_start: cursor_visible=1 and (101,50) is black.
- pixel_en=0 inside the cursor box -> pixel_out=0, cursor_hit=0, pixel_en_out=0 two cycles later.
